// File: rtl/data_deskewer.sv
// data_deskewer
//   Receive side of the diagonal wavefront protocol feeding the systolic array.
//   Collects 7 skewed 32-bit beats (four 8-bit lanes each) and rebuilds a
//   4x4 byte matrix presented as four aligned 32-bit rows on valid/ready.
//
// Ports
//   clk        rising-edge clock
//   st_rst_n   asynchronous active-low reset
//   a_or_b     skew orientation (0 = A row-skewed, 1 = B column-skewed), taken with beat 0
//   in_valid   arr_in carries a beat
//   in_ready   block accepts beats (low only while a matrix is held)
//   arr_in     skewed beat, lane l = bits [8l+7:8l]
//   arr_out    reassembled rows arr_out[0..3], zero unless a matrix is held
//   out_valid  arr_out holds a complete matrix
//   out_ready  downstream takes the matrix
//   done       one-cycle pulse registered on the output transfer edge
module data_deskewer (
  input  logic             clk,
  input  logic             st_rst_n,
  input  logic             a_or_b,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      arr_in,
  output logic [0:3][31:0] arr_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             done
);

  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, HOLD = 2'd2} state_e;

  state_e               state_q;
  logic [2:0]           cnt_q;
  logic                 mode_q;
  logic                 out_valid_q;
  logic                 done_q;
  logic [3:0][3:0][7:0] rows_q;   // [row][byte]
  logic [3:0][3:0][7:0] rows_d;

  logic       accept;
  logic       xfer;
  logic       mode_eff;
  logic [2:0] beat_idx;

  assign in_ready  = (state_q != HOLD);
  assign accept    = in_valid && in_ready;
  assign xfer      = (state_q == HOLD) && out_valid_q && out_ready;
  // Beat 0 arrives in IDLE: its index is 0 and its orientation comes straight
  // from a_or_b; later beats use the count and the latched orientation.
  assign beat_idx  = (state_q == IDLE) ? 3'd0 : cnt_q;
  assign mode_eff  = (state_q == IDLE) ? a_or_b : mode_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;

  // Each byte has exactly one (beat, lane) source; lanes not named for the
  // current beat are padding and never reach the rows.
  always_comb begin
    rows_d = rows_q;
    if (xfer) begin
      rows_d = '0;
    end else if (accept) begin
      for (int r = 0; r < 4; r++) begin
        for (int b = 0; b < 4; b++) begin
          if (mode_eff) begin
            if (int'(beat_idx) == 6 - r - b) rows_d[r][b] = arr_in[8*b +: 8];
          end else begin
            if (int'(beat_idx) == b + r) rows_d[r][b] = arr_in[8*(3-r) +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge st_rst_n) begin
    if (!st_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      rows_q      <= '0;
    end else begin
      rows_q <= rows_d;
      done_q <= xfer;
      case (state_q)
        IDLE: begin
          if (accept) begin
            mode_q  <= a_or_b;
            cnt_q   <= 3'd1;
            state_q <= COLLECT;
          end
        end
        COLLECT: begin
          if (accept) begin
            // Count saturates at 6: the beat-6 edge moves to HOLD instead.
            if (cnt_q == 3'd6) begin
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        HOLD: begin
          if (xfer) begin
            out_valid_q <= 1'b0;
            cnt_q       <= 3'd0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    arr_out = '0;
    if (state_q == HOLD) begin
      for (int r = 0; r < 4; r++) arr_out[r] = rows_q[r];
    end
  end

endmodule

// File: tb/tb_data_deskewer.sv
module tb_data_deskewer;

  logic             clk = 1'b0;
  logic             st_rst_n;
  logic             a_or_b;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      arr_in;
  logic [0:3][31:0] arr_out;
  logic             out_valid;
  logic             out_ready;
  logic             done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_on = 1'b0;

  data_deskewer dut (
    .clk(clk), .st_rst_n(st_rst_n), .a_or_b(a_or_b), .in_valid(in_valid),
    .in_ready(in_ready), .arr_in(arr_in), .arr_out(arr_out),
    .out_valid(out_valid), .out_ready(out_ready), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [0:3][31:0] REF = {32'h44332211, 32'h88776655, 32'hCCBBAA99, 32'h10FFEEDD};
  localparam logic [0:3][31:0] M2  = {32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};

  // Hand-derived beats for REF in each orientation.
  logic [31:0] beats_a [0:6];
  logic [31:0] beats_b [0:6];
  initial begin
    beats_a = '{32'h11000000, 32'h22550000, 32'h33669900, 32'h4477AADD,
                32'h0088BBEE, 32'h0000CCFF, 32'h00000010};
    beats_b = '{32'h10000000, 32'hCCFF0000, 32'h88BBEE00, 32'h4477AADD,
                32'h00336699, 32'h00002255, 32'h00000011};
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks accepted beats as whole words and decodes the matrix from the
  // orientation rules only when a matrix is complete.
  logic        m_hold, m_done, m_mode;
  int          m_cnt;
  logic [31:0] m_beats [0:6];

  always @(posedge clk or negedge st_rst_n) begin
    if (!st_rst_n) begin
      m_hold <= 1'b0; m_done <= 1'b0; m_cnt <= 0; m_mode <= 1'b0;
    end else begin
      m_done <= m_hold && out_ready;
      if (m_hold) begin
        if (out_ready) begin m_hold <= 1'b0; m_cnt <= 0; end
      end else if (in_valid) begin
        m_beats[m_cnt] <= arr_in;
        if (m_cnt == 0) m_mode <= a_or_b;
        m_cnt <= m_cnt + 1;
        if (m_cnt == 6) m_hold <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      logic [0:3][31:0] e;
      e = '0;
      if (m_hold) begin
        for (int r = 0; r < 4; r++)
          for (int b = 0; b < 4; b++)
            e[r][8*b +: 8] = m_mode ? m_beats[6-r-b][8*b +: 8] : m_beats[b+r][8*(3-r) +: 8];
      end
      chk("cyc_in_ready", 128'(in_ready), 128'(!m_hold));
      chk("cyc_out_valid", 128'(out_valid), 128'(m_hold));
      chk("cyc_done", 128'(done), 128'(m_done));
      chk("cyc_arr_out", arr_out, e);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] enc(input bit mode, input logic [0:3][31:0] m, input int j, input bit pad);
    logic [31:0] w;
    w = pad ? 32'hFFFFFFFF : 32'h0;
    for (int r = 0; r < 4; r++)
      for (int b = 0; b < 4; b++) begin
        if (mode && (j == 6 - r - b)) w[8*b +: 8] = m[r][8*b +: 8];
        if (!mode && (j == b + r))    w[8*(3-r) +: 8] = m[r][8*b +: 8];
      end
    return w;
  endfunction

  // Offers a beat until accepted, then drops in_valid and idles gap cycles.
  task automatic put(input logic [31:0] beat, input bit mode, input int gap, output int acc_cyc);
    bit ok;
    int n;
    in_valid = 1'b1; arr_in = beat; a_or_b = mode;
    n = 0; acc_cyc = -1;
    do begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 20);
    if (!ok) begin
      total++; bad++;
      $display("FAIL put_timeout beat=%h act=not_accepted exp=accepted", beat);
    end else acc_cyc = cyc;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic wait_valid(output int vcyc);
    int n;
    n = 0; vcyc = -1;
    @(negedge clk);
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    if (!out_valid) begin
      total++; bad++;
      $display("FAIL wait_valid_timeout act=0 exp=1");
    end else vcyc = cyc;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int c0, cx, vc;
    st_rst_n = 1'b0; a_or_b = 1'b0; in_valid = 1'b0; arr_in = '0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_arr_out", arr_out, 128'(0));
    @(posedge clk); #3 st_rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk_on = 1'b1;
    @(posedge clk); #1;

    // Mode B back-to-back
    for (int j = 0; j < 7; j++) begin put(beats_b[j], 1'b1, 0, cx); if (j == 0) c0 = cx; end
    wait_valid(vc);
    chk("b_latency", 128'(vc - c0), 128'(6));
    chk("b_rows", arr_out, REF);
    chk("b_hold_in_ready", 128'(in_ready), 128'(0));
    @(posedge clk); #1;
    repeat (2) begin @(posedge clk); #1; end

    // Mode A back-to-back
    for (int j = 0; j < 7; j++) begin put(beats_a[j], 1'b0, 0, cx); if (j == 0) c0 = cx; end
    wait_valid(vc);
    chk("a_latency", 128'(vc - c0), 128'(6));
    chk("a_rows", arr_out, REF);
    @(posedge clk); #1;
    repeat (2) begin @(posedge clk); #1; end

    // Mode B with gaps after beats 1 and 4, padding lanes 0xFF
    for (int j = 0; j < 7; j++) begin
      put(enc(1'b1, REF, j, 1'b1), 1'b1, (j == 1 || j == 4) ? 2 : 0, cx);
      if (j == 0) c0 = cx;
    end
    wait_valid(vc);
    chk("gap_latency", 128'(vc - c0), 128'(10));
    chk("gap_rows", arr_out, REF);
    @(posedge clk); #1;
    repeat (2) begin @(posedge clk); #1; end

    // Backpressure: out_ready low for 5 cycles, then overlapped second matrix
    out_ready = 1'b0;
    for (int j = 0; j < 7; j++) put(beats_a[j], 1'b0, 0, cx);
    wait_valid(vc);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 128'(out_valid), 128'(1));
      chk("bp_rows", arr_out, REF);
      chk("bp_done", 128'(done), 128'(0));
      if (k < 4) @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid = 1'b1; arr_in = enc(1'b1, M2, 0, 1'b0); a_or_b = 1'b1;
    @(posedge clk); #1;
    chk("xfer_done", 128'(done), 128'(1));
    chk("xfer_arr_out", arr_out, 128'(0));
    chk("xfer_in_ready", 128'(in_ready), 128'(1));
    chk("xfer_out_valid", 128'(out_valid), 128'(0));
    put(enc(1'b1, M2, 0, 1'b0), 1'b1, 0, cx);
    chk("done_one_cycle", 128'(done), 128'(0));
    for (int j = 1; j < 7; j++) put(enc(1'b1, M2, j, 1'b0), 1'b1, 0, cx);
    wait_valid(vc);
    chk("m2_rows", arr_out, M2);
    @(posedge clk); #1;
    repeat (2) begin @(posedge clk); #1; end

    // Async reset after beat 3
    for (int j = 0; j < 4; j++) put(beats_a[j], 1'b0, 0, cx);
    #2 st_rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 128'(out_valid), 128'(0));
    chk("arst_done", 128'(done), 128'(0));
    chk("arst_arr_out", arr_out, 128'(0));
    @(posedge clk); #3 st_rst_n = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    chk("arst_no_valid", 128'(out_valid), 128'(0));
    for (int j = 0; j < 7; j++) put(beats_a[j], 1'b0, 0, cx);
    wait_valid(vc);
    chk("arst_rows", arr_out, REF);
    @(posedge clk); #1;
    repeat (2) begin @(posedge clk); #1; end

    // a_or_b toggled after beat 0 of a Mode A stream
    for (int j = 0; j < 7; j++) put(beats_a[j], (j == 0) ? 1'b0 : 1'b1, 0, cx);
    wait_valid(vc);
    chk("toggle_rows", arr_out, REF);
    @(posedge clk); #1;
    repeat (3) begin @(posedge clk); #1; end

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
